oled_frame_arbiter: RTL and testbench
=====================================

// Module: oled_frame_arbiter
// PURPOSE
//  Shares the single OLED pixel_data input among N_SRC pixel renderers (task screens, audio meter).
//  Grants one renderer at a time, round-robin, and changes grant only on frame_begin to prevent tearing.
//  Sits between the renderers and Oled_Display; clocked by the 6.25 MHz OLED clock.
// PARAMETERS
//  N_SRC       4   number of requesting renderers (2..8)
//  PIX_W       16  pixel width (RGB565)
//  MIN_FRAMES  2   frames a requesting grantee keeps the display before preemption (0 treated as 1)
//  DEFAULT_SRC 0   source shown when nobody requests
// PORTS
//  CLK          in   1            OLED clock (6.25 MHz)
//  reset        in   1            async, active-high
//  frame_begin  in   1            1-cycle pulse from Oled_Display, CLK domain
//  req          in   N_SRC        level request per source
//  src_pixel    in   N_SRC*PIX_W  source s occupies bits [s*PIX_W +: PIX_W]
//  pixel_data   out  PIX_W        to Oled_Display
//  grant        out  N_SRC        one-hot current grantee
//  grant_idx    out  $clog2(N_SRC) binary grantee index
//  switch_pulse out  1            high 1 cycle after the edge on which grant changed
//  frames_held  out  8            frames completed by current grantee, saturates at 255
// BEHAVIOUR
//  - Reset (async): state IDLE, grant=1<<DEFAULT_SRC, grant_idx=DEFAULT_SRC, frames_held=0, switch_pulse=0.
//  - pixel_data = src_pixel[grant_idx] (comb mux off registered grant); 0 latency from src_pixel.
//  - req sampled ONLY in cycles where frame_begin=1; req changes between pulses have no effect.
//  - cand = first s with req[s]=1 scanning grant_idx+1, +2, ... wrapping, excluding grant_idx.
//  - done = frames_held+1 (frame just ended), evaluated at frame_begin.
//  - FSM, transitions on the edge where frame_begin=1:
//    IDLE: req==0 -> stay. Else grant := cand, or DEFAULT_SRC if it is the only requester -> HOLD.
//    HOLD: req==0 -> grant DEFAULT_SRC, IDLE.
//          req[grant_idx]=0 & cand valid -> switch now, MIN_FRAMES ignored.
//          req[grant_idx]=1 & cand valid & done>=MIN_FRAMES -> switch to cand.
//          otherwise -> frames_held := sat(done).
//    BLANK: exists only with macro (see CONFIGURATION).
//  - Any switch: frames_held := 0; switch_pulse=1 next cycle; new source drives pixel_data from the cycle after the frame_begin edge.
//  - Switch to DEFAULT_SRC on req==0 pulses switch_pulse only if grant_idx != DEFAULT_SRC.
//  - grant always one-hot; grant_idx always consistent with grant.
//  - Reset mid-frame: outputs return to reset values immediately, no clock needed.
// CONFIGURATION
//  ARB_BLANK_EN defined: every switch enters BLANK for one frame instead of HOLD/IDLE:
//    - grant already updated; pixel_data forced to {PIX_W{1'b0}} (black).
//    - req ignored during BLANK.
//    - at the next frame_begin -> HOLD, or IDLE if the new grantee is DEFAULT_SRC via req==0; frames_held stays 0.
//    - reset leaves BLANK immediately.
//  ARB_BLANK_EN undefined: no BLANK state; FSM is IDLE/HOLD only; pixel_data never forced.
// STRUCTURE
//  oled_arb_pkg:
//    - state enum {IDLE, HOLD, BLANK}
//    - PIX_BLACK constant
//    - FRAMES_SAT=8'd255
//  Sub-module rr_picker(N_SRC): comb round-robin search.
//    - in: req, grant_idx
//    - out: cand_idx, cand_valid
//  Top holds FSM, grant regs, frame counter, output mux.
// TESTING (N_SRC=4, MIN_FRAMES=2, DEFAULT_SRC=0, src_pixel[s]=16'h1111*(s+1))
//  1 Reset, req=0 -> grant=4'b0001, idx=0, frames_held=0, pixel_data=16'h1111; pulses keep IDLE.
//  2 req=4'b0110 steady, fb#1 -> grant 1, switch_pulse; fb#2 -> frames_held=1; fb#3 -> grant 2, frames_held=0; fb#5 -> grant 1.
//  3 grant 1 after 1 frame; req 0110->0100 mid-frame -> next fb grants 2 although done=1<MIN_FRAMES.
//  4 grant 3, req=4'b1001, fb -> wraps to grant 0, 4'b0001; req toggles 0000->1111->0000 between pulses -> no change.
//  5 grant 2, req drops to 0 -> fb -> grant 0, IDLE, pixel_data=16'h1111; reset mid-frame from grant 2 -> grant 0 same cycle.
//  6 ARB_BLANK_EN: switch 1->2 -> pixel_data=16'h0000 for one frame, then 16'h3333; req changes during BLANK ignored.

Source files
------------

// File: rtl/oled_arb_pkg.sv
// Shared definitions for the OLED frame arbiter: FSM encodings, black pixel
// value and the frames_held saturation limit with its increment helper.
package oled_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_HOLD  = 2'd1;
  localparam arb_state_t ST_BLANK = 2'd2;

  localparam logic [15:0] PIX_BLACK  = 16'h0000;
  localparam logic [7:0]  FRAMES_SAT = 8'd255;

  function automatic logic [7:0] frames_sat_inc(input logic [7:0] v);
    return (v == FRAMES_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/oled_frame_arbiter_rr_picker.sv
// Combinational round-robin search: nearest requester after grant_idx,
// wrapping around, never returning grant_idx itself.
module rr_picker #(
  parameter int N_SRC = 4,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] grant_idx,
  output logic [IDX_W-1:0] cand_idx,
  output logic             cand_valid
);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    cand_idx   = '0;
    cand_valid = 1'b0;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      if (req[(int'(grant_idx) + k) % N_SRC]) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'((int'(grant_idx) + k) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/oled_frame_arbiter.sv
// Frame-synchronous round-robin arbiter sharing the OLED pixel input among renderers.
// Optional macro ARB_BLANK_EN inserts one black frame after every grant change.
module oled_frame_arbiter #(
  parameter int N_SRC       = 4,
  parameter int PIX_W       = 16,
  parameter int MIN_FRAMES  = 2,
  parameter int DEFAULT_SRC = 0
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       frame_begin,
  input  logic [N_SRC-1:0]           req,
  input  logic [N_SRC*PIX_W-1:0]     src_pixel,
  output logic [PIX_W-1:0]           pixel_data,
  output logic [N_SRC-1:0]           grant,
  output logic [$clog2(N_SRC)-1:0]   grant_idx,
  output logic                       switch_pulse,
  output logic [7:0]                 frames_held
);
  import oled_arb_pkg::*;

  localparam int IDX_W = $clog2(N_SRC);
  localparam int MIN_EFF = (MIN_FRAMES < 1) ? 1 : MIN_FRAMES;
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_SRC);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [7:0]       frames_held_q, frames_held_d;
  logic             switch_pulse_q, switch_pulse_d;

  logic [IDX_W-1:0] cand_idx;
  logic             cand_valid;
  logic [8:0]       done;
  logic             min_met;
  logic             go_switch;
  logic             to_idle;
  logic [IDX_W-1:0] new_idx;

`ifdef ARB_BLANK_EN
  logic blank_idle_q, blank_idle_d;
`endif

  rr_picker #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_picker (
    .req        (req),
    .grant_idx  (grant_idx_q),
    .cand_idx   (cand_idx),
    .cand_valid (cand_valid)
  );

  assign done    = {1'b0, frames_held_q} + 9'd1;
  assign min_met = (done >= 9'(MIN_EFF));

  // All decisions happen only on frame_begin so the display never tears.
  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    frames_held_d  = frames_held_q;
    switch_pulse_d = 1'b0;
    go_switch      = 1'b0;
    to_idle        = 1'b0;
    new_idx        = grant_idx_q;
`ifdef ARB_BLANK_EN
    blank_idle_d   = blank_idle_q;
`endif
    if (frame_begin) begin
      case (state_q)
        ST_IDLE: begin
          if (req != '0) begin
            if (cand_valid) begin
              new_idx   = cand_idx;
              go_switch = 1'b1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (req == '0) begin
            if (grant_idx_q != DEF_IDX) begin
              new_idx   = DEF_IDX;
              to_idle   = 1'b1;
              go_switch = 1'b1;
            end else begin
              state_d       = ST_IDLE;
              frames_held_d = '0;
            end
          end else if (cand_valid && (!req[grant_idx_q] || min_met)) begin
            new_idx   = cand_idx;
            go_switch = 1'b1;
          end else begin
            frames_held_d = frames_sat_inc(frames_held_q);
          end
        end
`ifdef ARB_BLANK_EN
        ST_BLANK: begin
          state_d = blank_idle_q ? ST_IDLE : ST_HOLD;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    if (go_switch) begin
      grant_idx_d    = new_idx;
      frames_held_d  = '0;
      switch_pulse_d = 1'b1;
`ifdef ARB_BLANK_EN
      state_d        = ST_BLANK;
      blank_idle_d   = to_idle;
`else
      state_d        = to_idle ? ST_IDLE : ST_HOLD;
`endif
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_idx_q    <= DEF_IDX;
      frames_held_q  <= '0;
      switch_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_idx_q    <= grant_idx_d;
      frames_held_q  <= frames_held_d;
      switch_pulse_q <= switch_pulse_d;
    end
  end

`ifdef ARB_BLANK_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      blank_idle_q <= 1'b0;
    end else begin
      blank_idle_q <= blank_idle_d;
    end
  end
`endif

  always_comb begin
    grant              = '0;
    grant[grant_idx_q] = 1'b1;
  end

  always_comb begin
    pixel_data = src_pixel[int'(grant_idx_q)*PIX_W +: PIX_W];
`ifdef ARB_BLANK_EN
    if (state_q == ST_BLANK) begin
      pixel_data = PIX_W'(PIX_BLACK);
    end
`endif
  end

  assign grant_idx    = grant_idx_q;
  assign switch_pulse = switch_pulse_q;
  assign frames_held  = frames_held_q;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Self-checking bench for oled_frame_arbiter: frame-level behavioural model
// compared every cycle, plus directed hand-computed checkpoints.
module tb_oled_frame_arbiter;

  localparam int N_SRC       = 4;
  localparam int PIX_W       = 16;
  localparam int MIN_FRAMES  = 2;
  localparam int DEFAULT_SRC = 0;

  logic                   CLK = 1'b0;
  logic                   reset;
  logic                   frame_begin;
  logic [N_SRC-1:0]       req;
  logic [N_SRC*PIX_W-1:0] src_pixel;
  logic [PIX_W-1:0]       pixel_data;
  logic [N_SRC-1:0]       grant;
  logic [1:0]             grant_idx;
  logic                   switch_pulse;
  logic [7:0]             frames_held;

  int checks   = 0;
  int failures = 0;
  bit compare_on = 1'b0;

  always #5 CLK = ~CLK;

  oled_frame_arbiter #(
    .N_SRC(N_SRC), .PIX_W(PIX_W), .MIN_FRAMES(MIN_FRAMES), .DEFAULT_SRC(DEFAULT_SRC)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .frame_begin  (frame_begin),
    .req          (req),
    .src_pixel    (src_pixel),
    .pixel_data   (pixel_data),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .switch_pulse (switch_pulse),
    .frames_held  (frames_held)
  );

  // Frame-level model: who owns the display, whether anyone is holding it,
  // how many frames they kept it, and whether a black frame is being shown.
  int m_grant;
  bit m_hold;
  bit m_blank;
  bit m_blank_idle;
  bit m_pulse;
  int m_frames;

  function automatic void model_switch(input int g, input bit idle_after);
    m_grant  = g;
    m_frames = 0;
    m_pulse  = 1'b1;
`ifdef ARB_BLANK_EN
    m_blank      = 1'b1;
    m_blank_idle = idle_after;
    m_hold       = 1'b0;
`else
    m_hold = !idle_after;
`endif
  endfunction

  function automatic void model_frame(input logic [N_SRC-1:0] r);
    int nxt;
    nxt = -1;
    if (m_blank) begin
      m_blank = 1'b0;
      m_hold  = !m_blank_idle;
      return;
    end
    for (int k = 1; k < N_SRC; k++) begin
      if (nxt < 0 && r[(m_grant + k) % N_SRC]) nxt = (m_grant + k) % N_SRC;
    end
    if (r == '0) begin
      if (m_hold) begin
        if (m_grant != DEFAULT_SRC) model_switch(DEFAULT_SRC, 1'b1);
        else begin
          m_hold   = 1'b0;
          m_frames = 0;
        end
      end
    end else if (!m_hold) begin
      if (nxt >= 0) model_switch(nxt, 1'b0);
      else m_hold = 1'b1;
    end else if (nxt >= 0 && (!r[m_grant] || m_frames + 1 >= MIN_FRAMES)) begin
      model_switch(nxt, 1'b0);
    end else begin
      m_frames = (m_frames + 1 > 255) ? 255 : m_frames + 1;
    end
  endfunction

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_grant      = DEFAULT_SRC;
      m_hold       = 1'b0;
      m_blank      = 1'b0;
      m_blank_idle = 1'b0;
      m_pulse      = 1'b0;
      m_frames     = 0;
    end else begin
      m_pulse = 1'b0;
      if (frame_begin) model_frame(req);
    end
  end

  function automatic logic [PIX_W-1:0] model_pixel();
    if (m_blank) return '0;
    return src_pixel[m_grant*PIX_W +: PIX_W];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Every cycle, all outputs are compared against the frame-level model.
  always @(negedge CLK) begin
    if (compare_on) begin
      check_output("model_grant_idx", 32'(grant_idx), 32'(m_grant));
      check_output("model_grant", 32'(grant), 32'(1) << m_grant);
      check_output("model_frames_held", 32'(frames_held), 32'(m_frames));
      check_output("model_switch_pulse", 32'(switch_pulse), 32'(m_pulse));
      check_output("model_pixel", 32'(pixel_data), 32'(model_pixel()));
    end
  end

  task automatic apply_stimulus(input logic [N_SRC-1:0] new_req);
    req = new_req;
  endtask

  task automatic frame_pulse();
    frame_begin = 1'b1;
    @(posedge CLK);
    #2 frame_begin = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    reset       = 1'b1;
    frame_begin = 1'b0;
    req         = '0;
    for (int s = 0; s < N_SRC; s++) src_pixel[s*PIX_W +: PIX_W] = 16'(16'h1111 * (s + 1));
    compare_on = 1'b1;

    // Reset values, visible before any clock edge.
    #3;
    check_output("reset_grant", 32'(grant), 32'h1);
    check_output("reset_idx", 32'(grant_idx), 32'd0);
    check_output("reset_frames", 32'(frames_held), 32'd0);
    check_output("reset_pulse", 32'(switch_pulse), 32'd0);
    check_output("reset_pixel", 32'(pixel_data), 32'h1111);
    #10 reset = 1'b0;
    @(posedge CLK);
    #2;

    // Idle pulses with no requests leave the default source in place.
    frame_pulse();
    gap(2);
    frame_pulse();
    check_output("idle_grant", 32'(grant), 32'h1);
    check_output("idle_frames", 32'(frames_held), 32'd0);
    check_output("idle_pulse", 32'(switch_pulse), 32'd0);

`ifndef ARB_BLANK_EN
    // Round-robin between sources 1 and 2 with the minimum hold time.
    apply_stimulus(4'b0110);
    gap(1);
    frame_pulse();
    check_output("rr_fb1_grant", 32'(grant), 32'b0010);
    check_output("rr_fb1_pulse", 32'(switch_pulse), 32'd1);
    check_output("rr_fb1_pixel", 32'(pixel_data), 32'h2222);
    gap(1);
    check_output("rr_pulse_drop", 32'(switch_pulse), 32'd0);
    gap(2);
    frame_pulse();
    check_output("rr_fb2_frames", 32'(frames_held), 32'd1);
    check_output("rr_fb2_grant", 32'(grant), 32'b0010);
    gap(3);
    frame_pulse();
    check_output("rr_fb3_grant", 32'(grant), 32'b0100);
    check_output("rr_fb3_frames", 32'(frames_held), 32'd0);
    gap(3);
    frame_pulse();
    check_output("rr_fb4_frames", 32'(frames_held), 32'd1);
    gap(3);
    frame_pulse();
    check_output("rr_fb5_idx", 32'(grant_idx), 32'd1);

    // Grantee drops its request: switch immediately despite short hold.
    gap(1);
    apply_stimulus(4'b0100);
    gap(2);
    frame_pulse();
    check_output("drop_grant", 32'(grant), 32'b0100);
    check_output("drop_frames", 32'(frames_held), 32'd0);
    check_output("drop_pulse", 32'(switch_pulse), 32'd1);

    // Wrap from source 3 back to source 0.
    gap(2);
    apply_stimulus(4'b1000);
    gap(1);
    frame_pulse();
    check_output("wrap_to3_idx", 32'(grant_idx), 32'd3);
    gap(2);
    apply_stimulus(4'b1001);
    frame_pulse();
    check_output("wrap_hold_frames", 32'(frames_held), 32'd1);
    gap(2);
    frame_pulse();
    check_output("wrap_grant", 32'(grant), 32'b0001);
    check_output("wrap_pixel", 32'(pixel_data), 32'h1111);

    // Request churn between pulses has no effect on the grant.
    gap(1);
    apply_stimulus(4'b0000);
    gap(1);
    apply_stimulus(4'b1111);
    gap(1);
    apply_stimulus(4'b0000);
    gap(1);
    check_output("churn_grant", 32'(grant), 32'b0001);
    apply_stimulus(4'b1001);
    frame_pulse();
    check_output("churn_fb_grant", 32'(grant), 32'b0001);
    check_output("churn_fb_frames", 32'(frames_held), 32'd1);

    // Requests vanish: back to the default source.
    apply_stimulus(4'b0100);
    gap(2);
    frame_pulse();
    check_output("to2_grant", 32'(grant), 32'b0100);
    gap(2);
    apply_stimulus(4'b0000);
    gap(1);
    frame_pulse();
    check_output("release_grant", 32'(grant), 32'b0001);
    check_output("release_pulse", 32'(switch_pulse), 32'd1);
    check_output("release_pixel", 32'(pixel_data), 32'h1111);
    gap(2);
    frame_pulse();
    check_output("release_idle_pulse", 32'(switch_pulse), 32'd0);

    // Only the default source requests: hold without a switch, then saturate.
    apply_stimulus(4'b0001);
    frame_pulse();
    check_output("defonly_pulse", 32'(switch_pulse), 32'd0);
    check_output("defonly_frames0", 32'(frames_held), 32'd0);
    gap(1);
    frame_pulse();
    check_output("defonly_frames1", 32'(frames_held), 32'd1);
    repeat (260) begin
      gap(1);
      frame_pulse();
    end
    check_output("sat_frames", 32'(frames_held), 32'd255);
    apply_stimulus(4'b0000);
    frame_pulse();
    check_output("defonly_release_frames", 32'(frames_held), 32'd0);
    check_output("defonly_release_pulse", 32'(switch_pulse), 32'd0);

    // Reset mid-frame while source 2 owns the display.
    apply_stimulus(4'b0100);
    frame_pulse();
    gap(1);
    reset = 1'b1;
    #1;
    check_output("midreset_grant", 32'(grant), 32'b0001);
    check_output("midreset_pixel", 32'(pixel_data), 32'h1111);
    check_output("midreset_frames", 32'(frames_held), 32'd0);
    #3 reset = 1'b0;
    apply_stimulus(4'b0000);
    @(posedge CLK);
    #2;
`else
    // One black frame after every switch; requests ignored while blank.
    apply_stimulus(4'b0010);
    frame_pulse();
    check_output("blank_grant", 32'(grant), 32'b0010);
    check_output("blank_pixel", 32'(pixel_data), 32'h0000);
    check_output("blank_pulse", 32'(switch_pulse), 32'd1);
    gap(2);
    frame_pulse();
    check_output("unblank_pixel", 32'(pixel_data), 32'h2222);
    check_output("unblank_frames", 32'(frames_held), 32'd0);
    apply_stimulus(4'b0110);
    gap(2);
    frame_pulse();
    check_output("bl_hold_frames", 32'(frames_held), 32'd1);
    gap(2);
    frame_pulse();
    check_output("bl_sw2_grant", 32'(grant), 32'b0100);
    check_output("bl_sw2_pixel", 32'(pixel_data), 32'h0000);
    gap(1);
    apply_stimulus(4'b0001);
    gap(1);
    frame_pulse();
    check_output("bl_ignore_grant", 32'(grant), 32'b0100);
    check_output("bl_ignore_pixel", 32'(pixel_data), 32'h3333);
    check_output("bl_ignore_frames", 32'(frames_held), 32'd0);
    gap(2);
    apply_stimulus(4'b0000);
    frame_pulse();
    check_output("bl_release_pixel", 32'(pixel_data), 32'h0000);
    gap(2);
    frame_pulse();
    check_output("bl_release_after", 32'(pixel_data), 32'h1111);
`endif

    gap(3);
    compare_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
